// File: rtl/multi_pulse_sync_if.sv
// Bundled strobe/status signals for the clka->clkb multi-channel pulse synchroniser.
// master = producer/consumer side (bench or system), slave = synchroniser.
interface multi_pulse_sync_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] pulse_ina;
    logic            ovf_clr_a;
    logic [N_CH-1:0] pulse_outb;
    logic [N_CH-1:0] level_outb;
    logic [N_CH-1:0] busy_a;
    logic [N_CH-1:0] ovf_a;

    modport master (
        output pulse_ina,
        output ovf_clr_a,
        input  pulse_outb,
        input  level_outb,
        input  busy_a,
        input  ovf_a
    );

    modport slave (
        input  pulse_ina,
        input  ovf_clr_a,
        output pulse_outb,
        output level_outb,
        output busy_a,
        output ovf_a
    );
endinterface

// File: rtl/multi_pulse_sync.sv
// Per-channel four-phase req/ack pulse synchroniser, clka (fast) -> clkb (slow).
// Latency: 1 clka to req, then SYNC_STAGES clkb edges to pulse_outb.
// No backpressure: extra pulses queue in a saturating pending counter; overflow drops and sets sticky ovf_a.
module multi_pulse_sync #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic               clka,
    input  logic               clkb,
    input  logic               rst_n,
    multi_pulse_sync_if.slave  bus
);

    // Handshake phase is fully described by (req_a, ack_a).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_REQ   = 2'b10,
        ST_HOLD  = 2'b11
    } hs_state_e;

    logic [N_CH-1:0] pulse_vec;
    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] busy_vec;
    logic [N_CH-1:0] ovf_vec;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // clka domain
        logic                   req_q, req_d;
        logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
        logic [CNT_W-1:0]       pend_q, pend_d;
        logic                   ovf_q, ovf_d;
        logic                   busy_q, busy_d;
        logic                   ack_a;
        logic                   drop;
        hs_state_e              state;

        // clkb domain
        logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
        logic                   req_b_dly_q;
        logic                   req_b;

        assign ack_a = ack_sync_q[SYNC_STAGES-1];
        assign state = hs_state_e'({req_q, ack_a});
        assign req_b = req_sync_q[SYNC_STAGES-1];

        always_comb begin
            req_d      = req_q;
            pend_d     = pend_q;
            drop       = 1'b0;
            ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], req_b};

            case (state)
                ST_IDLE: begin
                    // A fresh pulse takes the launch slot; only a pend-only launch consumes the queue.
                    if (bus.pulse_ina[c] || (pend_q != '0)) begin
                        req_d = 1'b1;
                        if (!bus.pulse_ina[c]) begin
                            pend_d = pend_q - 1'b1;
                        end
                    end
                end
                ST_REQ:   req_d = 1'b1;
                ST_HOLD:  req_d = 1'b0;
                ST_DRAIN: req_d = 1'b0;
                default:  req_d = 1'b0;
            endcase

            if ((state != ST_IDLE) && bus.pulse_ina[c]) begin
                if (&pend_q) begin
                    drop = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end

            ovf_d  = drop | (ovf_q & ~bus.ovf_clr_a);
            busy_d = req_d | ack_sync_d[SYNC_STAGES-1] | (pend_d != '0);
        end

        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
                req_q      <= 1'b0;
                ack_sync_q <= '0;
                pend_q     <= '0;
                ovf_q      <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                req_q      <= req_d;
                ack_sync_q <= ack_sync_d;
                pend_q     <= pend_d;
                ovf_q      <= ovf_d;
                busy_q     <= busy_d;
            end
        end

        assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_q};

        always_ff @(posedge clkb or negedge rst_n) begin
            if (!rst_n) begin
                req_sync_q  <= '0;
                req_b_dly_q <= 1'b0;
            end else begin
                req_sync_q  <= req_sync_d;
                req_b_dly_q <= req_b;
            end
        end

        assign pulse_vec[c] = req_b & ~req_b_dly_q;
        assign level_vec[c] = req_b;
        assign busy_vec[c]  = busy_q;
        assign ovf_vec[c]   = ovf_q;
    end

    assign bus.pulse_outb = pulse_vec;
    assign bus.level_outb = level_vec;
    assign bus.busy_a     = busy_vec;
    assign bus.ovf_a      = ovf_vec;

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Directed bench for multi_pulse_sync: single pulse, queueing, overflow, multi-channel, reset, ratio sweep.
module tb_multi_pulse_sync;
    localparam int N_CH = 4;

    logic clka;
    logic clkb;
    logic rst_n;
    int   clkb_half;

    multi_pulse_sync_if #(.N_CH(N_CH)) bus ();

    multi_pulse_sync #(
        .N_CH        (N_CH),
        .SYNC_STAGES (2),
        .CNT_W       (3)
    ) dut (
        .clka  (clka),
        .clkb  (clkb),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clka edges at multiples of 50 (even); clkb edges kept odd so they never coincide.
    initial begin
        clka = 1'b0;
        forever #50 clka = ~clka;
    end

    initial begin
        clkb      = 1'b0;
        clkb_half = 218;
        #13;
        forever #(clkb_half) clkb = ~clkb;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int pcnt [N_CH];
    int last_edge [N_CH];
    int clkb_edges = 0;
    int dup = 0;
    logic [N_CH-1:0] prev_pulse = '0;

    always @(posedge clkb) clkb_edges++;

    always @(negedge clkb) begin
        for (int c = 0; c < N_CH; c++) begin
            if (bus.pulse_outb[c]) begin
                pcnt[c]++;
                last_edge[c] = clkb_edges;
                if (prev_pulse[c]) dup++;
            end
        end
        prev_pulse = bus.pulse_outb;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clka);
            #2;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy_a !== '0 && n < 4000) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.busy_a === '0), 32'd1);
    endtask

    int base [N_CH];
    int e_busy;
    int exp_cnt [N_CH];
    int n_poll;
    logic [N_CH-1:0] mask;

    task automatic snap();
        for (int c = 0; c < N_CH; c++) base[c] = pcnt[c];
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            pcnt[c]      = 0;
            last_edge[c] = 0;
        end
        rst_n         = 1'b0;
        bus.pulse_ina = '0;
        bus.ovf_clr_a = 1'b0;
        step(5);

        // Reset state
        chk("rst_busy",  32'(bus.busy_a),     32'h0);
        chk("rst_ovf",   32'(bus.ovf_a),      32'h0);
        chk("rst_level", 32'(bus.level_outb), 32'h0);
        chk("rst_pulse", 32'(bus.pulse_outb), 32'h0);
        rst_n = 1'b1;
        step(5);

        // Single pulse on ch0
        snap();
        bus.pulse_ina = 4'b0001;
        step(1);
        bus.pulse_ina = '0;
        e_busy = clkb_edges;
        chk("t1_busy", 32'(bus.busy_a), 32'h1);
        wait_idle("t1_idle");
        step(20);
        chk("t1_cnt0",  32'(pcnt[0] - base[0]), 32'd1);
        chk("t1_other", 32'((pcnt[1] - base[1]) + (pcnt[2] - base[2]) + (pcnt[3] - base[3])), 32'd0);
        chk("t1_lat",   32'((last_edge[0] > e_busy) && (last_edge[0] - e_busy <= 4)), 32'd1);
        chk("t1_level", 32'(bus.level_outb), 32'h0);
        chk("t1_busy0", 32'(bus.busy_a), 32'h0);

        // Five pulses on ch1, three clka apart
        snap();
        for (int i = 0; i < 5; i++) begin
            bus.pulse_ina = 4'b0010;
            step(1);
            bus.pulse_ina = '0;
            step(2);
        end
        wait_idle("t2_idle");
        step(20);
        chk("t2_cnt1", 32'(pcnt[1] - base[1]), 32'd5);
        chk("t2_ovf",  32'(bus.ovf_a), 32'h0);

        // Nine back-to-back pulses on ch2: 1 launched, 7 queued, 1 dropped
        snap();
        bus.pulse_ina = 4'b0100;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            if (i == 8) chk("t3_ovf_at8", 32'(bus.ovf_a), 32'h0);
            if (i == 9) chk("t3_ovf_at9", 32'(bus.ovf_a), 32'h4);
        end
        // Another drop together with a clear: the set must win
        bus.ovf_clr_a = 1'b1;
        step(1);
        bus.pulse_ina = '0;
        chk("t3_set_wins", 32'(bus.ovf_a), 32'h4);
        step(1);
        bus.ovf_clr_a = 1'b0;
        chk("t3_clr", 32'(bus.ovf_a), 32'h0);
        wait_idle("t3_idle");
        step(20);
        chk("t3_cnt2", 32'(pcnt[2] - base[2]), 32'd8);
        chk("t3_ovf_end", 32'(bus.ovf_a), 32'h0);

        // Same-cycle pulse on all channels, twice
        snap();
        bus.pulse_ina = 4'b1111;
        step(1);
        bus.pulse_ina = '0;
        step(2);
        bus.pulse_ina = 4'b1111;
        step(1);
        bus.pulse_ina = '0;
        wait_idle("t4_idle");
        step(20);
        for (int c = 0; c < N_CH; c++) chk($sformatf("t4_cnt%0d", c), 32'(pcnt[c] - base[c]), 32'd2);

        // Reset while ch3 is in HOLD with two pulses pending
        bus.pulse_ina = 4'b1000;
        step(3);
        bus.pulse_ina = '0;
        n_poll = 0;
        while (!bus.level_outb[3] && n_poll < 400) begin
            step(1);
            n_poll++;
        end
        chk("t5_level_seen", 32'(bus.level_outb[3]), 32'd1);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",  32'(bus.busy_a),     32'h0);
        chk("t5_rst_level", 32'(bus.level_outb), 32'h0);
        chk("t5_rst_pulse", 32'(bus.pulse_outb), 32'h0);
        chk("t5_rst_ovf",   32'(bus.ovf_a),      32'h0);
        snap();
        step(5);
        rst_n = 1'b1;
        step(600);
        chk("t5_no_pulse3", 32'(pcnt[3] - base[3]), 32'd0);
        chk("t5_busy",      32'(bus.busy_a), 32'h0);

        // Ratio sweep clkb = clka/1 .. clka/10 with random offset and random pulses
        for (int div = 1; div <= 10; div++) begin
            clkb_half = 50 * div + 2 * $urandom_range(0, 24);
            step(20);
            snap();
            for (int c = 0; c < N_CH; c++) exp_cnt[c] = 0;
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k < 6; k++) begin
                    mask = 4'($urandom_range(0, 15));
                    bus.pulse_ina = mask;
                    for (int c = 0; c < N_CH; c++) if (mask[c]) exp_cnt[c]++;
                    step(1);
                end
                bus.pulse_ina = '0;
                step($urandom_range(0, 10));
                wait_idle($sformatf("t6_idle_d%0d", div));
            end
            step(10);
            for (int c = 0; c < N_CH; c++)
                chk($sformatf("t6_d%0d_ch%0d", div, c), 32'(pcnt[c] - base[c]), 32'(exp_cnt[c]));
            chk($sformatf("t6_ovf_d%0d", div), 32'(bus.ovf_a), 32'h0);
        end

        chk("no_dup_pulse", 32'(dup), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
